// File: rtl/clause_queue_if.sv
// Clause queue handshake bundle: arbiter grant side plus BCP dequeue side.
// err_out is present only when CLAUSE_QUEUE_ERR_EN is defined.
interface clause_queue_if #(
  parameter int DEPTH           = 8,
  parameter int CLAUSE_WIDTH    = 4,
  parameter int ELEMENT_BIT_CNT = 11
);
  localparam int CW   = CLAUSE_WIDTH * ELEMENT_BIT_CNT;
  localparam int CNTW = $clog2(DEPTH + 1);

  logic            grant_in;
  logic [CW-1:0]   clause_in;
  logic            flush_in;
  logic            deq_ready_in;
  logic            full_out;
  logic            deq_valid_out;
  logic [CW-1:0]   deq_clause_out;
  logic [CNTW-1:0] count_out;
`ifdef CLAUSE_QUEUE_ERR_EN
  logic            err_out;

  modport master (
    output grant_in, clause_in, flush_in, deq_ready_in,
    input  full_out, deq_valid_out, deq_clause_out, count_out,
    input  err_out
  );
  modport slave (
    input  grant_in, clause_in, flush_in, deq_ready_in,
    output full_out, deq_valid_out, deq_clause_out, count_out,
    output err_out
  );
`else
  modport master (
    output grant_in, clause_in, flush_in, deq_ready_in,
    input  full_out, deq_valid_out, deq_clause_out, count_out
  );
  modport slave (
    input  grant_in, clause_in, flush_in, deq_ready_in,
    output full_out, deq_valid_out, deq_clause_out, count_out
  );
`endif
endinterface

// File: rtl/clause_queue.sv
// Clause FIFO between the clause arbiter and the BCP engine (FWFT head).
// Optional sticky error flag enabled by macro CLAUSE_QUEUE_ERR_EN.
module clause_queue #(
  parameter int DEPTH           = 8,
  parameter int CLAUSE_WIDTH    = 4,
  parameter int ELEMENT_BIT_CNT = 11
) (
  input logic          clock,
  input logic          reset,
  clause_queue_if.slave q
);
  localparam int CW   = CLAUSE_WIDTH * ELEMENT_BIT_CNT;
  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [CW-1:0]   mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CNTW-1:0] count;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full  = (count == CNTW'(DEPTH));
  assign empty = (count == '0);
  assign push  = q.grant_in & ~full & ~q.flush_in;
  assign pop   = q.deq_ready_in & ~empty & ~q.flush_in;

  // Pointer and occupancy update; flush beats push and pop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (q.flush_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop)  rd_ptr <= nxt(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage write; contents are not reset.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= q.clause_in;
  end

  assign q.full_out       = full;
  assign q.deq_valid_out  = ~empty;
  assign q.count_out      = count;
  assign q.deq_clause_out = mem[rd_ptr];

`ifdef CLAUSE_QUEUE_ERR_EN
  logic err_r;

  // Sticky on dropped push or pop-while-empty; flush clears.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_r <= 1'b0;
    end else if (q.flush_in) begin
      err_r <= 1'b0;
    end else if ((q.grant_in & full) | (q.deq_ready_in & empty)) begin
      err_r <= 1'b1;
    end
  end

  assign q.err_out = err_r;
`endif
endmodule

// File: tb/tb_clause_queue.sv
// Self-checking bench for clause_queue: vector table plus scoreboard.
// Covers DEPTH=8 main instance and a DEPTH=5 wrap instance.
module tb_clause_queue;
  localparam int CW = 44;

  typedef struct {
    logic          g;
    logic [CW-1:0] c;
    logic          f;
    logic          r;
    int            exp_cnt;
  } vec_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  clause_queue_if #(.DEPTH(8)) qi ();
  clause_queue_if #(.DEPTH(5)) q5 ();

  clause_queue #(.DEPTH(8)) dut (
    .clock (clock),
    .reset (reset),
    .q     (qi.slave)
  );

  clause_queue #(.DEPTH(5)) dut5 (
    .clock (clock),
    .reset (reset),
    .q     (q5.slave)
  );

  int checks = 0;
  int errors = 0;
  logic [CW-1:0] sb[$];
  logic [CW-1:0] sb5[$];
  vec_t tbl[18];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // One cycle on the DEPTH=8 instance with scoreboard upkeep.
  task automatic cyc(input logic g, input logic [CW-1:0] c,
                     input logic f, input logic r);
    logic do_push;
    qi.grant_in     = g;
    qi.clause_in    = c;
    qi.flush_in     = f;
    qi.deq_ready_in = r;
    do_push = g && !f && (sb.size() < 8);
    #3;
    if (!f && r && sb.size() > 0) begin
      chk("pop_data", qi.deq_clause_out, sb[0]);
      void'(sb.pop_front());
    end
    if (f) sb.delete();
    if (do_push) sb.push_back(c);
    @(posedge clock);
    #1;
    chk("count", 64'(qi.count_out), 64'(sb.size()));
    chk("full", 64'(qi.full_out), 64'(sb.size() == 8));
    chk("valid", 64'(qi.deq_valid_out), 64'(sb.size() != 0));
    if (sb.size() > 0) chk("head", qi.deq_clause_out, sb[0]);
  endtask

  // One cycle on the DEPTH=5 instance.
  task automatic cyc5(input logic g, input logic [CW-1:0] c,
                      input logic r);
    logic do_push;
    q5.grant_in     = g;
    q5.clause_in    = c;
    q5.flush_in     = 1'b0;
    q5.deq_ready_in = r;
    do_push = g && (sb5.size() < 5);
    #3;
    if (r && sb5.size() > 0) begin
      chk("d5_pop_data", q5.deq_clause_out, sb5[0]);
      void'(sb5.pop_front());
    end
    if (do_push) sb5.push_back(c);
    @(posedge clock);
    #1;
    chk("d5_count", 64'(q5.count_out), 64'(sb5.size()));
  endtask

  initial begin
    for (int i = 0; i < 8; i++)
      tbl[i] = '{1'b1, CW'(i + 1), 1'b0, 1'b0, i + 1};
    tbl[8] = '{1'b1, CW'('h0AA), 1'b0, 1'b1, 7};
    for (int i = 0; i < 7; i++)
      tbl[9 + i] = '{1'b0, CW'(0), 1'b0, 1'b1, 6 - i};
    tbl[16] = '{1'b1, CW'('h123), 1'b0, 1'b1, 1};
    tbl[17] = '{1'b0, CW'(0), 1'b0, 1'b1, 0};

    reset = 1'b1;
    qi.grant_in = 0; qi.clause_in = '0;
    qi.flush_in = 0; qi.deq_ready_in = 0;
    q5.grant_in = 0; q5.clause_in = '0;
    q5.flush_in = 0; q5.deq_ready_in = 0;
    #12;
    chk("rst_count", 64'(qi.count_out), 0);
    chk("rst_full", 64'(qi.full_out), 0);
    chk("rst_valid", 64'(qi.deq_valid_out), 0);
    chk("rst_count5", 64'(q5.count_out), 0);
`ifdef CLAUSE_QUEUE_ERR_EN
    chk("rst_err", 64'(qi.err_out), 0);
`endif
    reset = 1'b0;
    @(posedge clock);
    #1;

    for (int i = 0; i < 18; i++) begin
      cyc(tbl[i].g, tbl[i].c, tbl[i].f, tbl[i].r);
      chk($sformatf("tbl%0d_cnt", i), 64'(qi.count_out),
          64'(tbl[i].exp_cnt));
      if (i == 7) begin
        chk("fill_full", 64'(qi.full_out), 1);
        chk("fill_head", qi.deq_clause_out, 'h001);
      end
      if (i == 16)
        chk("bypass_head", qi.deq_clause_out, 'h123);
`ifdef CLAUSE_QUEUE_ERR_EN
      if (i == 8) chk("err_drop", 64'(qi.err_out), 1);
`endif
    end

    for (int i = 0; i < 4; i++) cyc(1'b1, CW'('h400 + i), 1'b0, 1'b0);
    cyc(1'b1, CW'('h0BB), 1'b1, 1'b0);
    chk("flush_count", 64'(qi.count_out), 0);
    chk("flush_valid", 64'(qi.deq_valid_out), 0);
`ifdef CLAUSE_QUEUE_ERR_EN
    chk("flush_err", 64'(qi.err_out), 0);
`endif

    for (int i = 0; i < 6; i++) cyc(1'b1, CW'('h500 + i), 1'b0, 1'b0);
    qi.grant_in = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("arst_count", 64'(qi.count_out), 0);
    chk("arst_full", 64'(qi.full_out), 0);
    chk("arst_valid", 64'(qi.deq_valid_out), 0);
    sb.delete();
    @(posedge clock);
    #2;
    reset = 1'b0;
    @(posedge clock);
    #1;
    cyc(1'b1, CW'('h055), 1'b0, 1'b0);
    chk("post_rst_head", qi.deq_clause_out, 'h055);
    cyc(1'b0, CW'(0), 1'b0, 1'b1);

    qi.deq_ready_in = 1'b0;
    for (int i = 0; i < 3; i++) cyc5(1'b1, CW'('h200 + i), 1'b0);
    for (int i = 0; i < 12; i++) cyc5(1'b1, CW'('h300 + i), 1'b1);
    for (int i = 0; i < 3; i++) cyc5(1'b0, CW'(0), 1'b1);
    chk("d5_drained", 64'(q5.deq_valid_out), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
